// File: rtl/cordic_sweep_ctrl.sv
// Angle-sweep sequencer for a pipelined sine/cosine CORDIC. It issues one angle per clock and
// pairs each returning result with its sweep index through a latency-matched tag pipeline.
module cordic_sweep_ctrl #(
    parameter int unsigned SZ         = 16,
    parameter int unsigned ANG_W      = 32,
    parameter int unsigned CORDIC_LAT = 17,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned XIN_INIT   = 19429
) (
    input  logic             CLK_100MHZ,
    input  logic             RST_N,
    input  logic             start,
    input  logic             abort,
    input  logic [ANG_W-1:0] start_angle,
    input  logic [ANG_W-1:0] angle_step,
    input  logic [CNT_W-1:0] num_points,
    output logic             busy,
    output logic             done,
    output logic [ANG_W-1:0] cordic_angle,
    output logic [SZ-1:0]    cordic_xin,
    output logic [SZ-1:0]    cordic_yin,
    input  logic [SZ:0]      cordic_xout,
    input  logic [SZ:0]      cordic_yout,
    output logic             res_valid,
    output logic [CNT_W-1:0] res_index,
    output logic [SZ:0]      res_cos,
    output logic [SZ:0]      res_sin
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StFin
    } state_e;

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [ANG_W-1:0]   angle_q, angle_d;
    logic [ANG_W-1:0]   step_q, step_d;
    logic [CNT_W-1:0]   npts_q, npts_d;
    logic [CNT_W-1:0]   k_q, k_d;

    logic [CORDIC_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [CNT_W-1:0]      tag_idx_q [CORDIC_LAT];
    logic [CNT_W-1:0]      tag_idx_d [CORDIC_LAT];

    logic               res_valid_q, res_valid_d;
    logic [CNT_W-1:0]   res_index_q, res_index_d;
    logic [SZ:0]        res_cos_q, res_cos_d;
    logic [SZ:0]        res_sin_q, res_sin_d;

    logic               push_vld;
    logic               tag_out_vld;
    logic               upstream_vld;
    logic               flush;

    assign tag_out_vld = tag_vld_q[CORDIC_LAT-1];
    assign flush       = abort && ((state_q == StIssue) || (state_q == StDrain));

    // Valid tags form one contiguous run, so the sweep has fully drained once the exiting
    // tag is valid and nothing valid remains behind it.
    always_comb begin
        upstream_vld = 1'b0;
        for (int i = 0; i < int'(CORDIC_LAT) - 1; i++) begin
            upstream_vld = upstream_vld | tag_vld_q[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        angle_d  = angle_q;
        step_d   = step_q;
        npts_d   = npts_q;
        k_d      = k_q;
        push_vld = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (num_points != '0) begin
                        angle_d = start_angle;
                        step_d  = angle_step;
                        npts_d  = num_points;
                        k_d     = '0;
                        busy_d  = 1'b1;
                        state_d = StIssue;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StIssue: begin
                push_vld = 1'b1;
                angle_d  = angle_q + step_q;
                k_d      = k_q + CNT_W'(1);
                if (k_q == npts_q - CNT_W'(1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (tag_out_vld && !upstream_vld) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (flush) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    // Tag shift register: stage 0 takes the point issued this cycle, the last stage lines up
    // with the CORDIC output for that point.
    always_comb begin
        tag_vld_d    = tag_vld_q;
        tag_idx_d    = tag_idx_q;
        tag_vld_d[0] = push_vld;
        tag_idx_d[0] = k_q;
        for (int i = 1; i < int'(CORDIC_LAT); i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_idx_d[i] = tag_idx_q[i-1];
        end
        if (flush) begin
            tag_vld_d = '0;
        end
    end

    always_comb begin
        res_valid_d = 1'b0;
        res_index_d = res_index_q;
        res_cos_d   = res_cos_q;
        res_sin_d   = res_sin_q;
        if (tag_out_vld && !flush) begin
            res_valid_d = 1'b1;
            res_index_d = tag_idx_q[CORDIC_LAT-1];
            res_cos_d   = cordic_xout;
            res_sin_d   = cordic_yout;
        end
    end

    always_ff @(posedge CLK_100MHZ) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            angle_q     <= '0;
            step_q      <= '0;
            npts_q      <= '0;
            k_q         <= '0;
            tag_vld_q   <= '0;
            for (int i = 0; i < int'(CORDIC_LAT); i++) begin
                tag_idx_q[i] <= '0;
            end
            res_valid_q <= 1'b0;
            res_index_q <= '0;
            res_cos_q   <= '0;
            res_sin_q   <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            angle_q     <= angle_d;
            step_q      <= step_d;
            npts_q      <= npts_d;
            k_q         <= k_d;
            tag_vld_q   <= tag_vld_d;
            for (int i = 0; i < int'(CORDIC_LAT); i++) begin
                tag_idx_q[i] <= tag_idx_d[i];
            end
            res_valid_q <= res_valid_d;
            res_index_q <= res_index_d;
            res_cos_q   <= res_cos_d;
            res_sin_q   <= res_sin_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign cordic_angle = angle_q;
    assign cordic_xin   = SZ'(XIN_INIT);
    assign cordic_yin   = '0;
    assign res_valid    = res_valid_q;
    assign res_index    = res_index_q;
    assign res_cos      = res_cos_q;
    assign res_sin      = res_sin_q;

endmodule

// File: doc/cordic_sweep_ctrl.md
Name: cordic_sweep_ctrl

Overview:
Sequencer that drives the pipelined sine_cosine CORDIC through an angle sweep: latches a start angle, step and point count, then issues one angle per clock.
A latency-matched tag pipeline pairs each CORDIC output with its sweep index and marks it valid.
The block sits between a configuration/host interface and the CORDIC instance, replacing hand-driven angle stimulus.
It reports busy/done status and supports abort.

Parameters:
SZ, 16, CORDIC data precision; Xin/Yin are SZ bits, Xout/Yout are SZ+1 bits
ANG_W, 32, angle width; full scale 2^ANG_W = 360 degrees
CORDIC_LAT, 17, clocks from angle presented to matching Xout/Yout valid
CNT_W, 16, width of point count and index
XIN_INIT, 19429, X seed = 32000/1.647 (pre-divided by CORDIC gain)

Ports:
CLK_100MHZ  in  1  system clock
RST_N  in  1  synchronous active-low reset
start  in  1  one-cycle request to begin a sweep; sampled only in IDLE
abort  in  1  cancel sweep in progress
start_angle  in  ANG_W  first angle
angle_step  in  ANG_W  per-point increment, unsigned modulo 2^ANG_W
num_points  in  CNT_W  points to issue
busy  out  1  high from sweep accept until done/abort
done  out  1  one-cycle pulse at sweep completion
cordic_angle  out  ANG_W  registered angle to CORDIC
cordic_xin  out  SZ  constant XIN_INIT
cordic_yin  out  SZ  constant 0
cordic_xout  in  SZ+1  CORDIC cosine result
cordic_yout  in  SZ+1  CORDIC sine result
res_valid  out  1  registered result strobe
res_index  out  CNT_W  sweep index of result
res_cos  out  SZ+1  captured cordic_xout
res_sin  out  SZ+1  captured cordic_yout

Behaviour:
- Reset (RST_N=0 at a clock edge): state IDLE; busy=0, done=0, cordic_angle=0, res_valid=0, res_index=0, res_cos=0, res_sin=0; tag pipeline cleared. cordic_xin/cordic_yin are constants and unaffected.
- Reset asserted mid-sweep behaves the same as reset; no done pulse is produced.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE, start=1, num_points!=0: latch config; cordic_angle<=start_angle; issue counter k<=0; busy<=1; go ISSUE.
- IDLE, start=1, num_points=0: go FIN; busy stays 0; no point issued.
- IDLE otherwise: cordic_angle holds its last value.
- ISSUE: each cycle cordic_angle carries point k. Push {valid=1, index=k} into a CORDIC_LAT-deep tag shift register. Next cycle cordic_angle<=cordic_angle+angle_step (wraps mod 2^ANG_W); k<=k+1. On k=num_points-1 go DRAIN.
- DRAIN: push invalid tags; when the last valid tag leaves the pipeline, go FIN.
- FIN: done=1 for exactly one cycle; busy<=0; go IDLE.
- Result path: when the tag exiting the shift register is valid, on the next edge res_valid<=1, res_index<=tag index, res_cos<=cordic_xout, res_sin<=cordic_yout. Otherwise res_valid<=0 and the data outputs hold.
- Latency: point issued in cycle t (cordic_angle holds it) → res_valid high in cycle t+CORDIC_LAT+1.
- Results arrive in index order, back-to-back with no gaps.
- abort=1 in ISSUE or DRAIN: flush all tags invalid; next cycle busy=0, res_valid=0, state IDLE; no done pulse. abort in IDLE or FIN is ignored.
- abort and start in the same cycle while in IDLE: start wins (abort is ignored in IDLE).
- start while busy or in FIN is ignored; the config inputs are not re-latched.
- Config inputs are sampled only on accept; changes during a sweep have no effect.

Test Plan:
- Quarter sweep, CORDIC_LAT=17: start_angle=0, angle_step=0x40000000, num_points=4 → cordic_angle 0, 0x40000000, 0x80000000, 0xC0000000 on consecutive cycles. res_valid high 4 cycles starting 18 cycles after the first issue, index 0..3; res_cos≈+32000, 0, -32000, 0 (±0.2%). done pulses once, the cycle after busy's last high cycle... busy falls when done pulses.
- Wrap: start_angle=0xC0000000, angle_step=0x40000000, num_points=3 → angles 0xC0000000, 0x00000000, 0x40000000; indices 0..2.
- 1° sweep: start_angle=0, angle_step=11930464, num_points=360 → 360 contiguous res_valid cycles with indices 0..359; res_sin at index 90 ≈ +32000; exactly one done pulse.
- Zero points: num_points=0, start=1 → done pulse the cycle after FIN entry; busy stays 0; no res_valid.
- Abort at issue index 5 of 20 → busy=0 next cycle; res_valid never asserts afterwards; done never pulses. A new start is then accepted normally.
- Start while busy, and RST_N=0 at index 10 → the second start is ignored (no re-latch). After reset, all outputs are at reset values and no stale res_valid appears within CORDIC_LAT+2 cycles.
